// File: rtl/bit_debounce_sync.sv
// Debounces one raw asynchronous input into a clean synchronous level with rise/fall pulses.
// Optional saturating glitch counter output enabled by BIT_DEBOUNCE_GLITCH_CNT_EN.
module bit_debounce_sync #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in,
    output logic       out,
    output logic       rise,
    output logic       fall
`ifdef BIT_DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StLow,
        StWaitHi,
        StHigh,
        StWaitLo
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   out_q, out_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    // Only sync_q[0] ever sees the raw input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StLow;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            StLow: begin
                if (s) begin
                    state_d = StWaitHi;
                    cnt_d   = CntOne;
                end
            end
            StWaitHi: begin
                if (!s) begin
                    state_d = StLow;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StHigh;
                    out_d   = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StHigh: begin
                if (!s) begin
                    state_d = StWaitLo;
                    cnt_d   = CntOne;
                end
            end
            StWaitLo: begin
                if (s) begin
                    state_d = StHigh;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StLow;
                    out_d   = 1'b0;
                    fall_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = StLow;
                cnt_d   = '0;
                out_d   = 1'b0;
            end
        endcase
    end

    assign out  = out_q;
    assign rise = rise_q;
    assign fall = fall_q;

`ifdef BIT_DEBOUNCE_GLITCH_CNT_EN
    logic       abort;
    logic [7:0] glitch_q;

    // An abort is any wait state falling back to the level it started from.
    assign abort = ((state_q == StWaitHi) && !s) || ((state_q == StWaitLo) && s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_q <= '0;
        end else if (abort && (glitch_q != 8'hFF)) begin
            glitch_q <= glitch_q + 8'd1;
        end
    end

    assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_bit_debounce_sync.sv
// Directed bench for bit_debounce_sync at default parameters.
// Glitch counter checks are active when BIT_DEBOUNCE_GLITCH_CNT_EN is defined.
module tb_bit_debounce_sync;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic in    = 1'b0;
    logic out;
    logic rise;
    logic fall;
`ifdef BIT_DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

    int total  = 0;
    int bad    = 0;
    int rise_n = 0;
    int fall_n = 0;
    int both_n = 0;

    always #5 clk = ~clk;

    bit_debounce_sync #(
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .in   (in),
        .out  (out),
        .rise (rise),
        .fall (fall)
`ifdef BIT_DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_cnt(glitch_cnt)
`endif
    );

    // One clock edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
        if (rise) rise_n++;
        if (fall) fall_n++;
        if (rise && fall) both_n++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr();
        rise_n = 0;
        fall_n = 0;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset with in held high
        rst_n = 1'b0;
        in    = 1'b1;
        run(3);
        chk("reset_outs", {13'd0, out, rise, fall}, 16'd0);
        rst_n = 1'b1;
        clr();
        run(5);                                // edges 0..4
        chk("rel_e4_out", {15'd0, out}, 16'd0);
        chk("rel_e4_norise", 16'(rise_n), 16'd0);
        step();                                // edge 5
        chk("rel_e5_out_rise", {14'd0, out, rise}, 16'b11);
        step();                                // edge 6
        chk("rel_e6_rise_low", {14'd0, out, rise}, 16'b10);
`ifdef BIT_DEBOUNCE_GLITCH_CNT_EN
        chk("rel_glitch0", {8'd0, glitch_cnt}, 16'd0);
`endif

        // Clean fall: low captured at step 1, fall at step 6
        in = 1'b0;
        clr();
        run(5);
        chk("fall_e4_out", {15'd0, out}, 16'd1);
        step();
        chk("fall_e5", {13'd0, out, rise, fall}, 16'b001);
        step();
        chk("fall_e6", {13'd0, out, rise, fall}, 16'b000);

        // Clean 0->1->0 with a 20-cycle high
        in = 1'b1;
        clr();
        run(20);
        chk("clean_rise_cnt", 16'(rise_n), 16'd1);
        chk("clean_high_out", {15'd0, out}, 16'd1);
        in = 1'b0;
        clr();
        run(5);
        chk("clean_e4_out", {15'd0, out}, 16'd1);
        step();
        chk("clean_e5_fall", {13'd0, out, rise, fall}, 16'b001);
        step();
        chk("clean_fall_cnt", 16'(fall_n), 16'd1);

        // Two-cycle glitch is rejected
        run(5);
        clr();
        in = 1'b1;
        run(2);
        in = 1'b0;
        run(10);
        chk("glitch_out", {15'd0, out}, 16'd0);
        chk("glitch_norise", 16'(rise_n), 16'd0);
`ifdef BIT_DEBOUNCE_GLITCH_CNT_EN
        chk("glitch_cnt1", {8'd0, glitch_cnt}, 16'd1);
`endif

        // Bounce train, then hold high
        clr();
        for (int i = 0; i < 30; i++) begin
            in = ((i % 2) == 0);
            step();
        end
        in = 1'b1;
        run(5);
        chk("bounce_out", {15'd0, out}, 16'd0);
        chk("bounce_norise", 16'(rise_n), 16'd0);
        step();
        chk("bounce_rise", {14'd0, out, rise}, 16'b11);
        run(5);
        chk("bounce_rise_once", 16'(rise_n), 16'd1);
        chk("never_both", 16'(both_n), 16'd0);

        // Reset asserted while counting up with cnt == 2
        in = 1'b0;
        run(10);
        chk("pre_mid_out", {15'd0, out}, 16'd0);
        in = 1'b1;
        clr();
        run(4);
        chk("mid_cnt2", 16'(dut.cnt_q), 16'd2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {13'd0, out, rise, fall}, 16'd0);
        chk("mid_rst_cnt", 16'(dut.cnt_q), 16'd0);
        #2;
        rst_n = 1'b1;
`ifdef BIT_DEBOUNCE_GLITCH_CNT_EN
        chk("mid_rst_glitch", {8'd0, glitch_cnt}, 16'd0);
`endif
        clr();
        run(5);
        chk("mid_e4_out", {15'd0, out}, 16'd0);
        chk("mid_e4_norise", 16'(rise_n), 16'd0);
        step();
        chk("mid_e5_rise", {14'd0, out, rise}, 16'b11);

`ifdef BIT_DEBOUNCE_GLITCH_CNT_EN
        // Saturation of the glitch counter
        in = 1'b0;
        run(10);
        clr();
        for (int i = 0; i < 300; i++) begin
            in = 1'b1;
            run(2);
            in = 1'b0;
            run(2);
        end
        run(5);
        chk("sat_cnt", {8'd0, glitch_cnt}, 16'd255);
        chk("sat_out", {15'd0, out}, 16'd0);
        chk("sat_norise", 16'(rise_n), 16'd0);
        in = 1'b1;
        run(2);
        in = 1'b0;
        run(10);
        chk("sat_hold", {8'd0, glitch_cnt}, 16'd255);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
